// File: rtl/subtractor_pkg.sv
// subtractor_pkg: shared types and sizing for the bit-serial subtractor
//   state_t   : FSM states (IDLE, SHIFT)
//   DEF_WIDTH : default operand/result width
//   CNT_W     : bit-counter width for the default width
package subtractor_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 4;
    localparam int CNT_W     = $clog2(DEF_WIDTH);

endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: combinational 1-bit subtractor cell, d = a - b - br_in
//   a, b   : operand bits
//   br_in  : incoming borrow
//   d      : difference bit
//   br_out : outgoing borrow
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic br_in,
    output logic d,
    output logic br_out
);

    assign d      = a ^ b ^ br_in;
    assign br_out = (~a & b) | (~(a ^ b) & br_in);

endmodule

// File: rtl/subtractor_4bits_serial.sv
// subtractor_4bits_serial: bit-serial Diff = A - B - bin, LSB first, WIDTH cycles
//   clk, rst_n      : clock, asynchronous active-low reset
//   start, ready    : request accepted on an edge where ready=1
//   A, B, bin       : minuend, subtrahend, borrow-in (latched at acceptance)
//   done            : one-cycle pulse when results update
//   Diff, bout      : registered difference and final borrow
//   overflow        : registered two's-complement overflow
module subtractor_4bits_serial
    import subtractor_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             bin,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             bout,
    output logic             overflow
);

    localparam int CW = (WIDTH == DEF_WIDTH) ? CNT_W : $clog2(WIDTH);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res;
    logic             br;
    logic             d;
    logic             br_nx;
    logic             last;
    logic [WIDTH-1:0] res_nx;

    full_subtractor u_fs (
        .a      (a_sr[0]),
        .b      (b_sr[0]),
        .br_in  (br),
        .d      (d),
        .br_out (br_nx)
    );

    assign last   = cnt == CW'(WIDTH - 1);
    assign res_nx = {d, res[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            a_sr     <= '0;
            b_sr     <= '0;
            res      <= '0;
            br       <= 1'b0;
            ready    <= 1'b1;
            done     <= 1'b0;
            Diff     <= '0;
            bout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    a_sr  <= A;
                    b_sr  <= B;
                    br    <= bin;
                    res   <= '0;
                    cnt   <= '0;
                    ready <= 1'b0;
                    state <= SHIFT;
                end
                SHIFT: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    br   <= br_nx;
                    res  <= res_nx;
                    cnt  <= cnt + 1'b1;
                    if (last) begin
                        // on the last bit the shift-register LSBs hold the operand MSBs
                        Diff     <= res_nx;
                        bout     <= br_nx;
                        overflow <= (a_sr[0] ^ b_sr[0]) & (d ^ a_sr[0]);
                        done     <= 1'b1;
                        ready    <= 1'b1;
                        cnt      <= '0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
